exponent_subtractor_serial: RTL

- Bit-serial exponent subtractor for the floating adder's alignment stage.
- Computes a - b one bit per cycle with a full-subtractor cell. Also computes the sign and absolute difference, which the mantissa aligner uses as its shift amount.
- Trades the ripple adder's combinational depth for WIDTH+1 cycles of latency.
- Uses a valid/ready handshake on both sides.

---
 rtl/exponent_subtractor_serial.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/exponent_subtractor_serial.sv
`default_nettype none
// ============================================================================
// Module   : exponent_subtractor_serial
// Function : Bit-serial a - b exponent subtractor with sign, equality and
//            magnitude outputs for the float adder's alignment stage.
//            Optional magnitude clamp is enabled by defining EXP_SUB_CLAMP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module exponent_subtractor_serial #(
  parameter int WIDTH     = 8,
  parameter int CLAMP_MAX = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic [WIDTH-1:0] out_abs,
  output logic             out_a_lt_b,
  output logic             out_eq,
  output logic             out_clamped,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int              c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

`ifdef EXP_SUB_CLAMP_EN
  localparam bit c_CLAMP_EN = 1'b1;
`else
  localparam bit c_CLAMP_EN = 1'b0;
`endif

  localparam logic [WIDTH-1:0] c_CLAMP_VAL = WIDTH'(CLAMP_MAX);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic [c_CW-1:0]  r_cnt;

  logic             w_load;
  logic             w_shift;
  logic             w_fix;
  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_abs;
  logic             w_clamp_hit;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (in_valid)          w_state_nxt = S_RUN;
      S_RUN:  if (r_cnt == c_LAST)   w_state_nxt = S_FIX;
      S_FIX:                         w_state_nxt = S_DONE;
      S_DONE: if (out_ready)         w_state_nxt = S_IDLE;
      default:                       w_state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs and datapath strobes
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_load    = 1'b0;
    w_shift   = 1'b0;
    w_fix     = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        w_load   = in_valid;
      end
      S_RUN:   w_shift   = 1'b1;
      S_FIX:   w_fix     = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Full-subtractor cell on the operand LSBs
  assign w_d    = r_a[0] ^ r_b[0] ^ r_borrow;
  assign w_bout = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_borrow);

  // Final borrow set means the raw difference is negative: negate for magnitude
  assign w_abs       = r_borrow ? (~r_diff + {{(WIDTH-1){1'b0}}, 1'b1}) : r_diff;
  assign w_clamp_hit = c_CLAMP_EN && (32'(w_abs) > $unsigned(CLAMP_MAX));

  // Serial datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_diff      <= '0;
      r_borrow    <= 1'b0;
      r_cnt       <= '0;
      out_diff    <= '0;
      out_abs     <= '0;
      out_a_lt_b  <= 1'b0;
      out_eq      <= 1'b0;
      out_clamped <= 1'b0;
    end else begin
      if (w_load) begin
        r_a      <= in_a;
        r_b      <= in_b;
        r_diff   <= '0;
        r_borrow <= 1'b0;
        r_cnt    <= '0;
      end else if (w_shift) begin
        r_a      <= {1'b0, r_a[WIDTH-1:1]};
        r_b      <= {1'b0, r_b[WIDTH-1:1]};
        r_diff   <= {w_d, r_diff[WIDTH-1:1]};
        r_borrow <= w_bout;
        r_cnt    <= r_cnt + {{(c_CW-1){1'b0}}, 1'b1};
      end
      if (w_fix) begin
        out_diff    <= r_diff;
        out_abs     <= w_clamp_hit ? c_CLAMP_VAL : w_abs;
        out_a_lt_b  <= r_borrow;
        out_eq      <= (r_diff == '0);
        out_clamped <= w_clamp_hit;
      end
    end
  end

endmodule
`default_nettype wire
